// File: rtl/nios_system_mutex_bank_if.sv
// Avalon-MM slave bundle for the mutex bank: word address, strobes, write/read data and the level irq.
// The master side drives the strobes and the slave side returns combinational read data and irq.
interface nios_system_mutex_bank_if #(
    parameter int ADDR_W = 3
);
    logic [ADDR_W-1:0] address;
    logic              chipselect;
    logic              read;
    logic              write;
    logic [31:0]       data_from_cpu;
    logic [31:0]       data_to_cpu;
    logic              irq;

    modport master (
        output address, chipselect, read, write, data_from_cpu,
        input  data_to_cpu, irq
    );

    modport slave (
        input  address, chipselect, read, write, data_from_cpu,
        output data_to_cpu, irq
    );
endinterface

// File: rtl/nios_system_mutex_bank.sv
// Bank of owner/value hardware mutexes with sticky reset flags, optional lease timeout and release irq.
// Zero-latency combinational reads, writes take effect on the next edge; the slave never stalls.
module nios_system_mutex_bank #(
    parameter int NUM_MUTEX    = 4,
    parameter int ADDR_W       = 3,
    parameter int LEASE_W      = 16,
    parameter int LEASE_CYCLES = 0
) (
    input  logic                    clk,
    input  logic                    reset,
    nios_system_mutex_bank_if.slave bus
);
    localparam logic [LEASE_W-1:0] LEASE_INIT = LEASE_W'(LEASE_CYCLES);
    localparam logic [LEASE_W-1:0] LEASE_ONE  = LEASE_W'(1);
    localparam bit                 LEASE_EN   = (LEASE_CYCLES != 0);

    logic [15:0]          r_value [NUM_MUTEX];
    logic [15:0]          r_owner [NUM_MUTEX];
    logic [LEASE_W-1:0]   r_lease [NUM_MUTEX];
    logic [NUM_MUTEX-1:0] r_rel_pend;
    logic [NUM_MUTEX-1:0] r_expired;
    logic [NUM_MUTEX-1:0] r_irq_en;
    logic [NUM_MUTEX-1:0] r_rst_flag;

    logic [ADDR_W-1:0]    w_idx;
    logic                 w_wr_cycle;
    logic [15:0]          w_wr_owner;
    logic [15:0]          w_wr_value;
    logic [NUM_MUTEX-1:0] w_sel;
    logic [NUM_MUTEX-1:0] w_accept;
    logic [NUM_MUTEX-1:0] w_lock;
    logic [NUM_MUTEX-1:0] w_release;
    logic [NUM_MUTEX-1:0] w_expire;
    logic [NUM_MUTEX-1:0] w_status_wr;
    logic [31:0]          w_rdata;
    logic                 w_unused;

    assign w_idx      = bus.address >> 1;
    assign w_wr_cycle = bus.chipselect & bus.write;
    assign w_wr_owner = bus.data_from_cpu[31:16];
    assign w_wr_value = bus.data_from_cpu[15:0];
    assign w_unused   = bus.read;

    // Indices at or above NUM_MUTEX never match any w_sel bit, so they read 0 and ignore writes.
    always_comb begin
        w_sel       = '0;
        w_accept    = '0;
        w_lock      = '0;
        w_release   = '0;
        w_expire    = '0;
        w_status_wr = '0;
        for (int i = 0; i < NUM_MUTEX; i++) begin
            w_sel[i]       = (w_idx == ADDR_W'(i));
            w_accept[i]    = w_sel[i] & w_wr_cycle & ~bus.address[0] &
                             ((r_value[i] == 16'd0) | (r_owner[i] == w_wr_owner));
            w_lock[i]      = w_accept[i] & (w_wr_value != 16'd0);
            w_release[i]   = w_accept[i] & (w_wr_value == 16'd0) & (r_value[i] != 16'd0);
            w_expire[i]    = LEASE_EN & (r_value[i] != 16'd0) & (r_lease[i] == LEASE_ONE) &
                             ~w_accept[i];
            w_status_wr[i] = w_sel[i] & w_wr_cycle & bus.address[0];
        end
    end

    always_ff @(posedge clk) begin
        for (int i = 0; i < NUM_MUTEX; i++) begin
            if (reset) begin
                r_value[i]    <= '0;
                r_owner[i]    <= '0;
                r_lease[i]    <= '0;
                r_rel_pend[i] <= 1'b0;
                r_expired[i]  <= 1'b0;
                r_irq_en[i]   <= 1'b0;
                r_rst_flag[i] <= 1'b1;
            end else begin
                if (w_accept[i]) begin
                    r_owner[i] <= w_wr_owner;
                    r_value[i] <= w_wr_value;
                    if (w_lock[i]) begin
                        r_lease[i] <= LEASE_INIT;
                    end else if (w_release[i]) begin
                        r_lease[i] <= '0;
                    end
                end else if (w_expire[i]) begin
                    r_value[i] <= '0;
                    r_owner[i] <= '0;
                    r_lease[i] <= '0;
                end else if (LEASE_EN && r_value[i] != 16'd0 && r_lease[i] > LEASE_ONE) begin
                    r_lease[i] <= r_lease[i] - LEASE_ONE;
                end

                // Hardware events take priority over a same-cycle write-one-to-clear.
                if (w_release[i] | w_expire[i]) begin
                    r_rel_pend[i] <= 1'b1;
                end else if (w_status_wr[i] & bus.data_from_cpu[1]) begin
                    r_rel_pend[i] <= 1'b0;
                end

                if (w_expire[i]) begin
                    r_expired[i] <= 1'b1;
                end else if (w_status_wr[i] & bus.data_from_cpu[3]) begin
                    r_expired[i] <= 1'b0;
                end

                if (w_status_wr[i]) begin
                    r_irq_en[i] <= bus.data_from_cpu[2];
                end

                if (w_status_wr[i] & bus.data_from_cpu[0]) begin
                    r_rst_flag[i] <= 1'b0;
                end
            end
        end
    end

    always_comb begin
        w_rdata = '0;
        for (int i = 0; i < NUM_MUTEX; i++) begin
            if (w_sel[i]) begin
                w_rdata = bus.address[0] ?
                          {16'(r_lease[i]), 12'd0, r_expired[i], r_irq_en[i], r_rel_pend[i], r_rst_flag[i]} :
                          {r_owner[i], r_value[i]};
            end
        end
    end

    assign bus.data_to_cpu = w_rdata;
    assign bus.irq         = |(r_rel_pend & r_irq_en);
endmodule

// File: tb/tb_nios_system_mutex_bank.sv
// Directed bench: bank A has 4 mutexes with a 10-cycle lease, bank B has 3 mutexes and no lease.
// Table vectors cover the register map; hand sequences cover lease timing and edge collisions.
module tb_nios_system_mutex_bank;
    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    nios_system_mutex_bank_if #(.ADDR_W(3)) ifa ();
    nios_system_mutex_bank_if #(.ADDR_W(3)) ifb ();

    nios_system_mutex_bank #(
        .NUM_MUTEX(4), .ADDR_W(3), .LEASE_W(16), .LEASE_CYCLES(10)
    ) u_dut_a (
        .clk   (clk),
        .reset (reset),
        .bus   (ifa)
    );

    nios_system_mutex_bank #(
        .NUM_MUTEX(3), .ADDR_W(3), .LEASE_W(16), .LEASE_CYCLES(0)
    ) u_dut_b (
        .clk   (clk),
        .reset (reset),
        .bus   (ifb)
    );

    int checks = 0;
    int passes = 0;

    typedef struct {
        bit          dut;
        bit          wr;
        logic [2:0]  addr;
        logic [31:0] dat;
        logic        exp_irq;
        string       name;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(input bit d, input bit w, input logic [2:0] a,
                                input logic [31:0] v, input logic ei, input string n);
        vec_t r;
        r.dut = d; r.wr = w; r.addr = a; r.dat = v; r.exp_irq = ei; r.name = n;
        return r;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    endtask

    task automatic drive(input bit d, input logic [2:0] a, input logic cs, input logic w,
                         input logic r, input logic [31:0] wd);
        if (d) begin
            ifb.address = a; ifb.chipselect = cs; ifb.write = w; ifb.read = r; ifb.data_from_cpu = wd;
        end else begin
            ifa.address = a; ifa.chipselect = cs; ifa.write = w; ifa.read = r; ifa.data_from_cpu = wd;
        end
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic bus_wr(input bit d, input logic [2:0] a, input logic [31:0] wd);
        drive(d, a, 1'b1, 1'b1, 1'b0, wd);
        step(1);
        drive(d, a, 1'b0, 1'b0, 1'b0, 32'h0);
    endtask

    task automatic bus_rd(input bit d, input logic [2:0] a, output logic [31:0] q, output logic irq);
        drive(d, a, 1'b1, 1'b0, 1'b1, 32'h0);
        #1;
        q   = d ? ifb.data_to_cpu : ifa.data_to_cpu;
        irq = d ? ifb.irq : ifa.irq;
        drive(d, a, 1'b0, 1'b0, 1'b0, 32'h0);
    endtask

    task automatic rd_check(input bit d, input logic [2:0] a, input logic [31:0] exp, input string name);
        logic [31:0] q;
        logic        irq;
        bus_rd(d, a, q, irq);
        check(name, q, exp);
    endtask

    // Counts consecutive cycles the MUTEX word stays nonzero, bounded so a stuck lock cannot hang.
    task automatic hold_cycles(input logic [2:0] a, output int n);
        logic [31:0] q;
        logic        irq;
        n = 0;
        bus_rd(1'b0, a, q, irq);
        while (q != 32'h0 && n < 50) begin
            n++;
            step(1);
            bus_rd(1'b0, a, q, irq);
        end
    endtask

    initial begin
        logic [31:0] q;
        logic        irq;
        int          n;

        vecs.push_back(mk(0, 0, 3'd3, 32'h0000_0001, 0, "a_st1_reset"));
        vecs.push_back(mk(0, 0, 3'd0, 32'h0000_0000, 0, "a_mx0_reset"));
        vecs.push_back(mk(0, 1, 3'd3, 32'h0000_0001, 0, "wr"));
        vecs.push_back(mk(0, 0, 3'd3, 32'h0000_0000, 0, "a_st1_rstclr"));
        vecs.push_back(mk(0, 0, 3'd1, 32'h0000_0001, 0, "a_st0_rstkeep"));
        vecs.push_back(mk(0, 0, 3'd5, 32'h0000_0001, 0, "a_st2_rstkeep"));
        vecs.push_back(mk(0, 0, 3'd7, 32'h0000_0001, 0, "a_st3_rstkeep"));
        vecs.push_back(mk(0, 1, 3'd0, 32'h00AA_0005, 0, "wr"));
        vecs.push_back(mk(0, 0, 3'd0, 32'h00AA_0005, 0, "a_mx0_lock"));
        vecs.push_back(mk(0, 1, 3'd0, 32'h00BB_0007, 0, "wr"));
        vecs.push_back(mk(0, 0, 3'd0, 32'h00AA_0005, 0, "a_mx0_reject"));
        vecs.push_back(mk(0, 1, 3'd0, 32'h00AA_0000, 0, "wr"));
        vecs.push_back(mk(0, 0, 3'd0, 32'h00AA_0000, 0, "a_mx0_release"));
        vecs.push_back(mk(0, 0, 3'd1, 32'h0000_0003, 0, "a_st0_relpend"));
        vecs.push_back(mk(0, 1, 3'd5, 32'h0000_0004, 0, "wr"));
        vecs.push_back(mk(0, 0, 3'd5, 32'h0000_0005, 0, "a_st2_irqen"));
        vecs.push_back(mk(0, 1, 3'd4, 32'h0011_0001, 0, "wr"));
        vecs.push_back(mk(0, 0, 3'd4, 32'h0011_0001, 0, "a_mx2_lock"));
        vecs.push_back(mk(0, 1, 3'd4, 32'h0011_0000, 0, "wr"));
        vecs.push_back(mk(0, 0, 3'd4, 32'h0011_0000, 1, "a_mx2_release"));
        vecs.push_back(mk(0, 0, 3'd5, 32'h0000_0007, 1, "a_st2_pend"));
        vecs.push_back(mk(0, 1, 3'd5, 32'h0000_0006, 0, "wr"));
        vecs.push_back(mk(0, 0, 3'd5, 32'h0000_0005, 0, "a_st2_w1c"));
        vecs.push_back(mk(1, 0, 3'd7, 32'h0000_0000, 0, "b_st3_oor"));
        vecs.push_back(mk(1, 1, 3'd6, 32'h0077_0007, 0, "wr"));
        vecs.push_back(mk(1, 0, 3'd6, 32'h0000_0000, 0, "b_mx3_oor"));
        vecs.push_back(mk(1, 1, 3'd7, 32'h0000_000F, 0, "wr"));
        vecs.push_back(mk(1, 0, 3'd7, 32'h0000_0000, 0, "b_st3_oor_wr"));
        vecs.push_back(mk(1, 0, 3'd0, 32'h0000_0000, 0, "b_mx0_untouched"));
        vecs.push_back(mk(1, 0, 3'd1, 32'h0000_0001, 0, "b_st0_untouched"));
        vecs.push_back(mk(1, 0, 3'd3, 32'h0000_0001, 0, "b_st1_untouched"));
        vecs.push_back(mk(1, 0, 3'd5, 32'h0000_0001, 0, "b_st2_untouched"));
        vecs.push_back(mk(1, 1, 3'd4, 32'h0044_0009, 0, "wr"));
        vecs.push_back(mk(1, 0, 3'd4, 32'h0044_0009, 0, "b_mx2_lock"));
        vecs.push_back(mk(1, 0, 3'd5, 32'h0000_0001, 0, "b_st2_nolease"));

        reset = 1'b1;
        drive(0, 3'd0, 1'b0, 1'b0, 1'b0, 32'h0);
        drive(1, 3'd0, 1'b0, 1'b0, 1'b0, 32'h0);
        step(3);
        reset = 1'b0;

        foreach (vecs[k]) begin
            if (vecs[k].wr) begin
                bus_wr(vecs[k].dut, vecs[k].addr, vecs[k].dat);
            end else begin
                bus_rd(vecs[k].dut, vecs[k].addr, q, irq);
                check(vecs[k].name, q, vecs[k].dat);
                check({vecs[k].name, "_irq"}, 32'(irq), 32'(vecs[k].exp_irq));
            end
        end

        // Without a lease the lock must survive indefinitely.
        step(20);
        rd_check(1, 3'd4, 32'h0044_0009, "b_mx2_no_expiry");
        rd_check(1, 3'd5, 32'h0000_0001, "b_st2_no_expiry");

        // Plain lease expiry on mutex 1.
        bus_wr(0, 3'd2, 32'h0033_0001);
        rd_check(0, 3'd3, 32'h000A_0000, "lease_loaded");
        hold_cycles(3'd2, n);
        check("lease_hold_cycles", 32'(n), 32'd10);
        rd_check(0, 3'd2, 32'h0000_0000, "lease_expired_mx");
        rd_check(0, 3'd3, 32'h0000_000A, "lease_expired_st");
        bus_wr(0, 3'd3, 32'h0000_000A);
        rd_check(0, 3'd3, 32'h0000_0000, "lease_flags_clr");

        // Owner re-lock after 5 cycles reloads the lease.
        bus_wr(0, 3'd2, 32'h0033_0001);
        step(4);
        bus_wr(0, 3'd2, 32'h0033_0002);
        rd_check(0, 3'd3, 32'h000A_0000, "relock_reload");
        hold_cycles(3'd2, n);
        check("relock_hold_cycles", 32'(n), 32'd10);
        bus_wr(0, 3'd3, 32'h0000_000A);

        // Owner release collides with lease_cnt==1: the write wins, no expiry.
        bus_wr(0, 3'd2, 32'h0033_0001);
        step(9);
        rd_check(0, 3'd3, 32'h0001_0000, "lease_at_one");
        bus_wr(0, 3'd2, 32'h0033_0000);
        rd_check(0, 3'd2, 32'h0033_0000, "collide_release_mx");
        rd_check(0, 3'd3, 32'h0000_0002, "collide_release_st");

        // W1C of rel_pend/expired in the very cycle expiry sets them: the set wins.
        bus_wr(0, 3'd3, 32'h0000_0002);
        rd_check(0, 3'd3, 32'h0000_0000, "relpend_clr");
        bus_wr(0, 3'd2, 32'h0033_0001);
        step(9);
        bus_wr(0, 3'd3, 32'h0000_000A);
        rd_check(0, 3'd2, 32'h0000_0000, "collide_w1c_mx");
        rd_check(0, 3'd3, 32'h0000_000A, "collide_w1c_st");

        // Reset during a held lease and a concurrent write.
        bus_wr(0, 3'd6, 32'h0055_0003);
        step(3);
        drive(0, 3'd6, 1'b1, 1'b1, 1'b0, 32'h0066_0004);
        reset = 1'b1;
        step(1);
        reset = 1'b0;
        drive(0, 3'd0, 1'b0, 1'b0, 1'b0, 32'h0);
        rd_check(0, 3'd6, 32'h0000_0000, "rst_mx3");
        rd_check(0, 3'd7, 32'h0000_0001, "rst_st3");
        rd_check(0, 3'd0, 32'h0000_0000, "rst_mx0");
        rd_check(0, 3'd1, 32'h0000_0001, "rst_st0");
        rd_check(0, 3'd3, 32'h0000_0001, "rst_st1");
        bus_rd(0, 3'd5, q, irq);
        check("rst_st2", q, 32'h0000_0001);
        check("rst_irq", 32'(irq), 32'd0);
        rd_check(1, 3'd4, 32'h0000_0000, "rst_b_mx2");

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule
